// File: rtl/vtx_xform_pkg.sv
// Shared Q8.8 constants, FSM state encoding and saturating add/sub helpers
// for the model-space vertex transform stage.
package vtx_xform_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCALE  = 3'd1,
    ST_ROLL   = 3'd2,
    ST_PITCH  = 3'd3,
    ST_YAW    = 3'd4,
    ST_TRANSL = 3'd5,
    ST_OUT    = 3'd6
  } state_t;

  // Clamp a 17-bit signed intermediate back into DW bits.
  function automatic logic [DW-1:0] satNarrow(input logic [DW:0] v);
    logic [DW-1:0] r;
    if (v[DW] != v[DW-1]) begin
      r = v[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] addSat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return satNarrow({a[DW-1], a} + {b[DW-1], b});
  endfunction

  function automatic logic [DW-1:0] subSat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return satNarrow({a[DW-1], a} - {b[DW-1], b});
  endfunction

endpackage

// File: rtl/vtx_xform_mulsat.sv
// Combinational signed Q8.8 multiply: full product, arithmetic shift (floor),
// saturate to the DW-bit range.
module vtx_xform_mulsat
  import vtx_xform_pkg::*;
(
  input  logic signed [DW-1:0] opA,
  input  logic signed [DW-1:0] opB,
  output logic        [DW-1:0] product
);

  logic signed [2*DW-1:0] prod_s;
  logic signed [2*DW-1:0] shifted_s;

  // Multiply, rescale and clamp.
  always_comb begin
    prod_s    = opA * opB;
    shifted_s = prod_s >>> FRAC;
    if (shifted_s > 32'sh0000_7FFF) begin
      product = SAT_MAX;
    end else if (shifted_s < 32'shFFFF_8000) begin
      product = SAT_MIN;
    end else begin
      product = shifted_s[DW-1:0];
    end
  end

endmodule

// File: rtl/vtx_xform.sv
// Vertex transform stage: scale, roll, pitch, yaw, translate on one shared
// multiplier, result presented through a valid/ready handshake.
module vtx_xform
  import vtx_xform_pkg::*;
(
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iEnable,
  input  logic          iInitObj,
  input  logic          iInitVtx,
  input  logic [DW-1:0] iScaleX,
  input  logic [DW-1:0] iScaleY,
  input  logic [DW-1:0] iScaleZ,
  input  logic [DW-1:0] iCosRoll,
  input  logic [DW-1:0] iCosPitch,
  input  logic [DW-1:0] iCosYaw,
  input  logic [DW-1:0] iSenRoll,
  input  logic [DW-1:0] iSenPitch,
  input  logic [DW-1:0] iSenYaw,
  input  logic [DW-1:0] iTranslX,
  input  logic [DW-1:0] iTranslY,
  input  logic [DW-1:0] iTranslZ,
  input  logic [DW-1:0] iVertexX,
  input  logic [DW-1:0] iVertexY,
  input  logic [DW-1:0] iVertexZ,
  input  logic          iReady,
  output logic          oValid,
  output logic [DW-1:0] oVtxX,
  output logic [DW-1:0] oVtxY,
  output logic [DW-1:0] oVtxZ,
  output logic          oBusy,
  output logic          oOverrun
);

  state_t        state_r;
  logic [1:0]    step_r;
  logic [DW-1:0] scaleX_r, scaleY_r, scaleZ_r;
  logic [DW-1:0] cosR_r, cosP_r, cosY_r, senR_r, senP_r, senY_r;
  logic [DW-1:0] trX_r, trY_r, trZ_r;
  logic [DW-1:0] vx_r, vy_r, vz_r;
  logic [DW-1:0] t0_r, t1_r, t2_r;
  logic [DW-1:0] mulA_s, mulB_s, mulP_s;
  logic          paramOpen_s;

  assign paramOpen_s = (state_r == ST_IDLE) || (state_r == ST_OUT);

  vtx_xform_mulsat uMul (
    .opA     (mulA_s),
    .opB     (mulB_s),
    .product (mulP_s)
  );

  // Per-state/step operand selection; steps 0..3 of a rotation produce the
  // four products in the order the combine step consumes them.
  always_comb begin
    mulA_s = 16'h0000;
    mulB_s = 16'h0000;
    case (state_r)
      ST_SCALE: begin
        case (step_r)
          2'd0:    begin mulA_s = vx_r; mulB_s = scaleX_r; end
          2'd1:    begin mulA_s = vy_r; mulB_s = scaleY_r; end
          default: begin mulA_s = vz_r; mulB_s = scaleZ_r; end
        endcase
      end
      ST_ROLL: begin
        case (step_r)
          2'd0:    begin mulA_s = vy_r; mulB_s = cosR_r; end
          2'd1:    begin mulA_s = vz_r; mulB_s = senR_r; end
          2'd2:    begin mulA_s = vy_r; mulB_s = senR_r; end
          default: begin mulA_s = vz_r; mulB_s = cosR_r; end
        endcase
      end
      ST_PITCH: begin
        case (step_r)
          2'd0:    begin mulA_s = vx_r; mulB_s = cosP_r; end
          2'd1:    begin mulA_s = vz_r; mulB_s = senP_r; end
          2'd2:    begin mulA_s = vx_r; mulB_s = senP_r; end
          default: begin mulA_s = vz_r; mulB_s = cosP_r; end
        endcase
      end
      ST_YAW: begin
        case (step_r)
          2'd0:    begin mulA_s = vx_r; mulB_s = cosY_r; end
          2'd1:    begin mulA_s = vy_r; mulB_s = senY_r; end
          2'd2:    begin mulA_s = vx_r; mulB_s = senY_r; end
          default: begin mulA_s = vy_r; mulB_s = cosY_r; end
        endcase
      end
      default: begin
        mulA_s = 16'h0000;
        mulB_s = 16'h0000;
      end
    endcase
  end

  // Transform FSM, parameter latch and registered outputs.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_r  <= ST_IDLE;
      step_r   <= 2'd0;
      scaleX_r <= 16'h0000; scaleY_r <= 16'h0000; scaleZ_r <= 16'h0000;
      cosR_r   <= 16'h0000; cosP_r   <= 16'h0000; cosY_r   <= 16'h0000;
      senR_r   <= 16'h0000; senP_r   <= 16'h0000; senY_r   <= 16'h0000;
      trX_r    <= 16'h0000; trY_r    <= 16'h0000; trZ_r    <= 16'h0000;
      vx_r     <= 16'h0000; vy_r     <= 16'h0000; vz_r     <= 16'h0000;
      t0_r     <= 16'h0000; t1_r     <= 16'h0000; t2_r     <= 16'h0000;
      oValid   <= 1'b0;
      oVtxX    <= 16'h0000; oVtxY    <= 16'h0000; oVtxZ    <= 16'h0000;
      oBusy    <= 1'b0;
      oOverrun <= 1'b0;
    end else if (!iEnable) begin
      state_r <= ST_IDLE;
      step_r  <= 2'd0;
      oValid  <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      if ((iInitObj && !paramOpen_s) || (iInitVtx && (state_r != ST_IDLE))) begin
        oOverrun <= 1'b1;
      end
      if (iInitObj && paramOpen_s) begin
        scaleX_r <= iScaleX;   scaleY_r <= iScaleY;   scaleZ_r <= iScaleZ;
        cosR_r   <= iCosRoll;  cosP_r   <= iCosPitch; cosY_r   <= iCosYaw;
        senR_r   <= iSenRoll;  senP_r   <= iSenPitch; senY_r   <= iSenYaw;
        trX_r    <= iTranslX;  trY_r    <= iTranslY;  trZ_r    <= iTranslZ;
      end
      case (state_r)
        ST_IDLE: begin
          if (iInitVtx) begin
            vx_r    <= iVertexX;
            vy_r    <= iVertexY;
            vz_r    <= iVertexZ;
            step_r  <= 2'd0;
            state_r <= ST_SCALE;
            oBusy   <= 1'b1;
          end
        end
        ST_SCALE: begin
          case (step_r)
            2'd0:    vx_r <= mulP_s;
            2'd1:    vy_r <= mulP_s;
            default: vz_r <= mulP_s;
          endcase
          if (step_r == 2'd2) begin
            step_r  <= 2'd0;
            state_r <= ST_ROLL;
          end else begin
            step_r <= step_r + 2'd1;
          end
        end
        ST_ROLL, ST_PITCH, ST_YAW: begin
          step_r <= step_r + 2'd1;
          case (step_r)
            2'd0: t0_r <= mulP_s;
            2'd1: t1_r <= mulP_s;
            2'd2: t2_r <= mulP_s;
            default: begin
              // Last product arrives straight from the multiplier.
              case (state_r)
                ST_ROLL: begin
                  vy_r    <= subSat(t0_r, t1_r);
                  vz_r    <= addSat(t2_r, mulP_s);
                  state_r <= ST_PITCH;
                end
                ST_PITCH: begin
                  vx_r    <= addSat(t0_r, t1_r);
                  vz_r    <= subSat(mulP_s, t2_r);
                  state_r <= ST_YAW;
                end
                default: begin
                  vx_r    <= subSat(t0_r, t1_r);
                  vy_r    <= addSat(t2_r, mulP_s);
                  state_r <= ST_TRANSL;
                end
              endcase
            end
          endcase
        end
        ST_TRANSL: begin
          vx_r    <= addSat(vx_r, trX_r);
          vy_r    <= addSat(vy_r, trY_r);
          vz_r    <= addSat(vz_r, trZ_r);
          state_r <= ST_OUT;
        end
        ST_OUT: begin
          if (!oValid) begin
            oVtxX  <= vx_r;
            oVtxY  <= vy_r;
            oVtxZ  <= vz_r;
            oValid <= 1'b1;
          end else if (iReady) begin
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          step_r  <= 2'd0;
          oValid  <= 1'b0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vtx_xform.sv
// Directed bench for vtx_xform: table of transform vectors plus hand-written
// backpressure, enable-abort and reset-abort sequences.
module tb_vtx_xform;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iEnable = 1'b0, iInitObj = 1'b0, iInitVtx = 1'b0, iReady = 1'b0;
  logic [15:0] iScaleX = 16'h0, iScaleY = 16'h0, iScaleZ = 16'h0;
  logic [15:0] iCosRoll = 16'h0, iCosPitch = 16'h0, iCosYaw = 16'h0;
  logic [15:0] iSenRoll = 16'h0, iSenPitch = 16'h0, iSenYaw = 16'h0;
  logic [15:0] iTranslX = 16'h0, iTranslY = 16'h0, iTranslZ = 16'h0;
  logic [15:0] iVertexX = 16'h0, iVertexY = 16'h0, iVertexZ = 16'h0;
  logic        oValid, oBusy, oOverrun;
  logic [15:0] oVtxX, oVtxY, oVtxZ;

  int total = 0;
  int bad   = 0;

  vtx_xform dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
    .iInitObj(iInitObj), .iInitVtx(iInitVtx),
    .iScaleX(iScaleX), .iScaleY(iScaleY), .iScaleZ(iScaleZ),
    .iCosRoll(iCosRoll), .iCosPitch(iCosPitch), .iCosYaw(iCosYaw),
    .iSenRoll(iSenRoll), .iSenPitch(iSenPitch), .iSenYaw(iSenYaw),
    .iTranslX(iTranslX), .iTranslY(iTranslY), .iTranslZ(iTranslZ),
    .iVertexX(iVertexX), .iVertexY(iVertexY), .iVertexZ(iVertexZ),
    .iReady(iReady), .oValid(oValid),
    .oVtxX(oVtxX), .oVtxY(oVtxY), .oVtxZ(oVtxZ),
    .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [15:0] sX, sY, sZ, cR, cP, cY, nR, nP, nY, tX, tY, tZ, vX, vY, vZ, eX, eY, eZ;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClock);
    #1;
  endtask

  task automatic setParams(input vec_t v);
    iScaleX = v.sX; iScaleY = v.sY; iScaleZ = v.sZ;
    iCosRoll = v.cR; iCosPitch = v.cP; iCosYaw = v.cY;
    iSenRoll = v.nR; iSenPitch = v.nP; iSenYaw = v.nY;
    iTranslX = v.tX; iTranslY = v.tY; iTranslZ = v.tZ;
  endtask

  // Present a vertex for one edge (edge 0), optionally with iInitObj.
  task automatic startVtx(input logic withObj, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z);
    iVertexX = x; iVertexY = y; iVertexZ = z;
    iInitVtx = 1'b1; iInitObj = withObj;
    tick();
    iInitVtx = 1'b0; iInitObj = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (oValid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume(input string name);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check({name, ".validDrop"}, {15'd0, oValid}, 16'h0000);
    check({name, ".busyDrop"},  {15'd0, oBusy},  16'h0000);
  endtask

  task automatic checkOut(input string name, input logic [15:0] ex, input logic [15:0] ey,
                          input logic [15:0] ez);
    check({name, ".x"}, oVtxX, ex);
    check({name, ".y"}, oVtxY, ey);
    check({name, ".z"}, oVtxZ, ez);
  endtask

  task automatic checkAllZero(input string name);
    check({name, ".valid"},   {15'd0, oValid},   16'h0000);
    check({name, ".busy"},    {15'd0, oBusy},    16'h0000);
    check({name, ".overrun"}, {15'd0, oOverrun}, 16'h0000);
    checkOut(name, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    int lat;
    int seen;
    string nm;

    // sX sY sZ | cR cP cY | sinR sinP sinY | tX tY tZ | vertex | expected
    vecs[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'hFF00, 16'h0080, 16'h0200, 16'hFF00, 16'h0080};
    vecs[1] = '{16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0300, 16'h0100, 16'h0100};
    vecs[2] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
                16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000};
    // roll 90: (0,1,0) -> (0,0,1)
    vecs[5] = '{16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
    // pitch 90: (1,0,0) -> (0,0,-1)
    vecs[6] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00};
    // translate overflow saturates high
    vecs[7] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                16'h2000, 16'h0000, 16'h0000, 16'h7000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    // 0.5 * (-1/256) floors to -1/256
    vecs[8] = '{16'h0080, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};

    // Reset state
    tick(); tick();
    checkAllZero("reset");
    iReset = 1'b0;
    iEnable = 1'b1;
    tick();

    // Table: params and vertex strobed together in IDLE
    for (int i = 0; i < 9; i++) begin
      nm = $sformatf("v%0d", i);
      setParams(vecs[i]);
      startVtx(1'b1, vecs[i].vX, vecs[i].vY, vecs[i].vZ);
      waitValid(lat);
      check({nm, ".lat"}, 16'(lat), 16'd17);
      checkOut(nm, vecs[i].eX, vecs[i].eY, vecs[i].eZ);
      consume(nm);
    end
    check("noOverrunYet", {15'd0, oOverrun}, 16'h0000);

    // Backpressure with a dropped vertex during the hold
    setParams(vecs[0]);
    startVtx(1'b1, 16'h0100, 16'h0200, 16'h0300);
    waitValid(lat);
    check("bp.lat", 16'(lat), 16'd17);
    for (int k = 0; k < 5; k++) begin
      nm = $sformatf("bp.hold%0d", k);
      if (k == 2) begin
        iVertexX = 16'h1111; iInitVtx = 1'b1;
      end else begin
        iInitVtx = 1'b0;
      end
      tick();
      check({nm, ".valid"}, {15'd0, oValid}, 16'h0001);
      checkOut(nm, 16'h0100, 16'h0200, 16'h0300);
    end
    iInitVtx = 1'b0;
    check("bp.overrun", {15'd0, oOverrun}, 16'h0001);
    consume("bp");
    tick(); tick(); tick();
    check("bp.dropped", {15'd0, oBusy}, 16'h0000);

    // Enable drop at edge 8: abort, params and overrun retained
    setParams(vecs[1]);
    iInitObj = 1'b1;
    tick();
    iInitObj = 1'b0;
    setParams(vecs[3]);
    startVtx(1'b0, 16'h0100, 16'h0000, 16'h0000);
    for (int k = 1; k <= 7; k++) tick();
    iEnable = 1'b0;
    tick();
    check("en.busy", {15'd0, oBusy}, 16'h0000);
    check("en.valid", {15'd0, oValid}, 16'h0000);
    iInitVtx = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      iInitVtx = 1'b0;
      if (oValid || oBusy) seen++;
    end
    check("en.quiet", 16'(seen), 16'd0);
    check("en.overrunKept", {15'd0, oOverrun}, 16'h0001);
    iEnable = 1'b1;
    startVtx(1'b0, 16'h0080, 16'h0000, 16'h0000);
    waitValid(lat);
    check("en.lat", 16'(lat), 16'd17);
    checkOut("en.kept", 16'h0200, 16'h0100, 16'h0100);
    consume("en");

    // Reset at edge 8: immediate clear, no partial vertex, params cleared
    startVtx(1'b0, 16'h0100, 16'h0000, 16'h0000);
    for (int k = 1; k <= 7; k++) tick();
    @(posedge iClock);
    iReset = 1'b1;
    #1;
    checkAllZero("rst");
    iReset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oValid || oBusy) seen++;
    end
    check("rst.quiet", 16'(seen), 16'd0);
    setParams(vecs[1]);
    startVtx(1'b0, 16'h0100, 16'h0000, 16'h0000);
    waitValid(lat);
    check("rst.lat", 16'(lat), 16'd17);
    checkOut("rst.zeroParams", 16'h0000, 16'h0000, 16'h0000);
    consume("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
